// File: rtl/salsa_pkg.sv
// Shared Salsa20 types, rotation amounts and helpers used by the
// quarter-round datapath and its bench.
package salsa_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
  } quartet_t;

  localparam int ROT_B = 7;
  localparam int ROT_C = 9;
  localparam int ROT_D = 13;
  localparam int ROT_A = 18;

  function automatic word_t rotl32(input word_t v, input logic [4:0] r);
    return (v << r) | (v >> (6'd32 - {1'b0, r}));
  endfunction

  // Step index 0..3; says whether a pipeline register follows that ARX step.
  function automatic bit reg_after_step(input int stages, input int step);
    case (stages)
      32'sd1:  return (step == 32'sd3);
      32'sd2:  return (step == 32'sd1) || (step == 32'sd3);
      32'sd4:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/quarter_round_if.sv
// Valid-qualified quartet bus used on both sides of the quarter-round pipeline.
interface quarter_round_if;
  import salsa_pkg::*;

  logic  valid;
  word_t a;
  word_t b;
  word_t c;
  word_t d;

  modport master (output valid, a, b, c, d);
  modport slave  (input  valid, a, b, c, d);

endinterface

// File: rtl/quarter_round_step.sv
// One combinational ARX step: o_q = i_x ^ rotl32(i_y + i_z, R).
module qr_step
  import salsa_pkg::*;
#(
  parameter int R = 7
) (
  input  word_t i_x,
  input  word_t i_y,
  input  word_t i_z,
  output word_t o_q
);

  word_t w_sum;

  assign w_sum = i_y + i_z;
  assign o_q   = i_x ^ rotl32(w_sum, 5'(R));

endmodule

// File: rtl/quarter_round.sv
// Pipelined Salsa20 quarter round; STAGES (1, 2 or 4) selects where the
// stage registers sit between the four ARX steps.
module quarter_round
  import salsa_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  quarter_round_if.slave         i_in,
  quarter_round_if.master        o_out
);

  if (!((STAGES == 32'sd1) || (STAGES == 32'sd2) || (STAGES == 32'sd4))) begin : g_bad_stages
    $error("quarter_round: STAGES must be 1, 2 or 4");
  end

  quartet_t w_in;
  quartet_t w_s1, w_r1;
  quartet_t w_s2, w_r2;
  quartet_t w_s3, w_r3;
  quartet_t w_s4;
  logic     w_v1, w_v2, w_v3;
  word_t    w_b1, w_c2, w_d3, w_a4;
  quartet_t r_out;
  logic     r_vout;

  assign w_in = {i_in.a, i_in.b, i_in.c, i_in.d};

  qr_step #(.R(ROT_B)) u_step_b (.i_x(w_in.b), .i_y(w_in.a), .i_z(w_in.d), .o_q(w_b1));
  assign w_s1 = {w_in.a, w_b1, w_in.c, w_in.d};

  if (reg_after_step(STAGES, 32'sd0)) begin : g_reg1
    quartet_t r_q;
    logic     r_v;
    // Stage after step 1: valid loads every cycle, data only with valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
        r_v <= 1'b0;
      end else begin
        r_v <= i_in.valid;
        if (i_in.valid) r_q <= w_s1;
      end
    end
    assign w_r1 = r_q;
    assign w_v1 = r_v;
  end else begin : g_thru1
    assign w_r1 = w_s1;
    assign w_v1 = i_in.valid;
  end

  qr_step #(.R(ROT_C)) u_step_c (.i_x(w_r1.c), .i_y(w_r1.b), .i_z(w_r1.a), .o_q(w_c2));
  assign w_s2 = {w_r1.a, w_r1.b, w_c2, w_r1.d};

  if (reg_after_step(STAGES, 32'sd1)) begin : g_reg2
    quartet_t r_q;
    logic     r_v;
    // Stage after step 2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
        r_v <= 1'b0;
      end else begin
        r_v <= w_v1;
        if (w_v1) r_q <= w_s2;
      end
    end
    assign w_r2 = r_q;
    assign w_v2 = r_v;
  end else begin : g_thru2
    assign w_r2 = w_s2;
    assign w_v2 = w_v1;
  end

  qr_step #(.R(ROT_D)) u_step_d (.i_x(w_r2.d), .i_y(w_r2.c), .i_z(w_r2.b), .o_q(w_d3));
  assign w_s3 = {w_r2.a, w_r2.b, w_r2.c, w_d3};

  if (reg_after_step(STAGES, 32'sd2)) begin : g_reg3
    quartet_t r_q;
    logic     r_v;
    // Stage after step 3
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
        r_v <= 1'b0;
      end else begin
        r_v <= w_v2;
        if (w_v2) r_q <= w_s3;
      end
    end
    assign w_r3 = r_q;
    assign w_v3 = r_v;
  end else begin : g_thru3
    assign w_r3 = w_s3;
    assign w_v3 = w_v2;
  end

  qr_step #(.R(ROT_A)) u_step_a (.i_x(w_r3.a), .i_y(w_r3.d), .i_z(w_r3.c), .o_q(w_a4));
  assign w_s4 = {w_a4, w_r3.b, w_r3.c, w_r3.d};

  // Output stage is always present so no input reaches an output combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_vout <= 1'b0;
    end else begin
      r_vout <= w_v3;
      if (w_v3) r_out <= w_s4;
    end
  end

  assign o_out.valid = r_vout;
  assign o_out.a     = r_out.a;
  assign o_out.b     = r_out.b;
  assign o_out.c     = r_out.c;
  assign o_out.d     = r_out.d;

endmodule

// File: tb/tb_quarter_round.sv
// Directed bench for quarter_round: one instance per legal STAGES value,
// all fed from the same input bus.
module tb_quarter_round;
  import salsa_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  quarter_round_if if_in ();
  quarter_round_if if_o1 ();
  quarter_round_if if_o2 ();
  quarter_round_if if_o4 ();

  quarter_round #(.STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .i_in(if_in.slave), .o_out(if_o1.master));
  quarter_round #(.STAGES(2)) dut2 (.clk(clk), .rst_n(rst_n), .i_in(if_in.slave), .o_out(if_o2.master));
  quarter_round #(.STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .i_in(if_in.slave), .o_out(if_o4.master));

  function automatic logic [31:0] rl(input logic [31:0] v, input int r);
    logic [63:0] t;
    t = {v, v} << r;
    return t[63:32];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] q);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = q;
    b = b ^ rl(a + d, 7);
    c = c ^ rl(b + a, 9);
    d = d ^ rl(c + b, 13);
    a = a ^ rl(d + c, 18);
    return {a, b, c, d};
  endfunction

  function automatic logic [128:0] get_out(input int s);
    case (s)
      1:       return {if_o1.valid, if_o1.a, if_o1.b, if_o1.c, if_o1.d};
      2:       return {if_o2.valid, if_o2.a, if_o2.b, if_o2.c, if_o2.d};
      4:       return {if_o4.valid, if_o4.a, if_o4.b, if_o4.c, if_o4.d};
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] q);
    if_in.valid = v;
    {if_in.a, if_in.b, if_in.c, if_in.d} = q;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 128'h0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    int sl[3] = '{1, 2, 4};
    logic [128:0] o;
    rst_n = 1'b0;
    drive(1'b0, 128'h0);
    #2;
    for (int i = 0; i < 3; i++) begin
      o = get_out(sl[i]);
      n_vec++;
      if (o !== 129'd0) begin
        n_err++;
        $display("FAIL reset_state S=%0d got %h want 0", sl[i], o);
      end
    end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_and_hold();
    logic [127:0] exp_q = {32'h981E8457, 32'h00000282, 32'h00050603, 32'hA110A004};
    logic [128:0] o;
    drive(1'b1, {32'd1, 32'd2, 32'd3, 32'd4});
    tick();
    drive(1'b0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    o = get_out(1);
    n_vec++;
    if (o !== {1'b1, exp_q}) begin
      n_err++;
      $display("FAIL single_shot got %h want %h", o, {1'b1, exp_q});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      o = get_out(1);
      n_vec++;
      if (o !== {1'b0, exp_q}) begin
        n_err++;
        $display("FAIL hold_idle%0d got %h want %h", i, o, {1'b0, exp_q});
      end
    end
  endtask

  task automatic test_chain();
    logic [127:0] cur = {32'd1, 32'd2, 32'd3, 32'd4};
    logic [127:0] exp_q;
    logic [128:0] o;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, cur);
      tick();
      drive(1'b0, cur);
      exp_q = model(cur);
      o = get_out(1);
      n_vec++;
      if (o !== {1'b1, exp_q}) begin
        n_err++;
        $display("FAIL chain_iter%0d got %h want %h", i, o, {1'b1, exp_q});
      end
      if (i == 2) begin
        n_vec++;
        if (o[127:0] !== {32'h35C58BD8, 32'h97922F1E, 32'h6163EC5C, 32'h627FFF1A}) begin
          n_err++;
          $display("FAIL chain_golden2 got %h", o[127:0]);
        end
      end
      if (i == 16) begin
        n_vec++;
        if (o[127:0] !== {32'hA452CA8B, 32'hB292A2CE, 32'hA609E0CF, 32'h9FE75F61}) begin
          n_err++;
          $display("FAIL chain_golden16 got %h", o[127:0]);
        end
      end
      cur = exp_q;
    end
  endtask

  task automatic test_corners();
    logic [128:0] o;
    drive(1'b1, 128'h0);
    tick();
    drive(1'b0, 128'h0);
    o = get_out(1);
    n_vec++;
    if (o !== {1'b1, 128'h0}) begin
      n_err++;
      $display("FAIL zero_vec got %h want valid zero", o);
    end
    drive(1'b1, {4{32'hFFFFFFFF}});
    tick();
    drive(1'b0, 128'h0);
    o = get_out(1);
    n_vec++;
    if (o !== {1'b1, 32'hF8038143, 32'h00000080, 32'hFFFF01FF, 32'h1FB00000}) begin
      n_err++;
      $display("FAIL all_ones got %h want 1f8038143_00000080_ffff01ff_1fb00000", o);
    end
  endtask

  task automatic test_back_to_back();
    int           sl[3] = '{1, 2, 4};
    logic         v[11];
    logic [127:0] q[11];
    logic [127:0] e[11];
    logic [128:0] o;
    int           idx;
    logic         ev;
    for (int i = 0; i < 11; i++) begin
      v[i] = (i != 5);
      q[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      e[i] = model(q[i]);
    end
    idle(5);
    for (int j = 0; j < 15; j++) begin
      if (j < 11) drive(v[j], q[j]);
      else        drive(1'b0, 128'h0);
      tick();
      for (int k = 0; k < 3; k++) begin
        idx = j - sl[k] + 1;
        ev  = (idx >= 0 && idx < 11) ? v[idx] : 1'b0;
        o   = get_out(sl[k]);
        n_vec++;
        if (o[128] !== ev) begin
          n_err++;
          $display("FAIL stream_valid S=%0d cyc%0d got %b want %b", sl[k], j, o[128], ev);
        end
        if (ev) begin
          n_vec++;
          if (o[127:0] !== e[idx]) begin
            n_err++;
            $display("FAIL stream_data S=%0d item%0d got %h want %h", sl[k], idx, o[127:0], e[idx]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int sl[3] = '{1, 2, 4};
    logic [128:0] o;
    idle(5);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, {$urandom(), $urandom(), $urandom(), $urandom()});
      tick();
    end
    drive(1'b0, 128'h0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      o = get_out(sl[i]);
      n_vec++;
      if (o !== 129'd0) begin
        n_err++;
        $display("FAIL midreset_clear S=%0d got %h want 0", sl[i], o);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        o = get_out(sl[i]);
        n_vec++;
        if (o !== 129'd0) begin
          n_err++;
          $display("FAIL midreset_stale S=%0d cyc%0d got %h want 0", sl[i], c, o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_and_hold();
    test_chain();
    test_corners();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
